// File: rtl/gesture_cmd_decoder_pkg.sv
// Gesture command decoder: shared byte codes, command codes and helpers.
// Also used by the gesture transmitter side.
package gesture_cmd_decoder_pkg;

  localparam logic [7:0] ASCII_F    = 8'h66;
  localparam logic [7:0] ASCII_B    = 8'h62;
  localparam logic [7:0] ASCII_R    = 8'h72;
  localparam logic [7:0] ASCII_L    = 8'h6C;
  localparam logic [7:0] ASCII_N    = 8'h6E;
  localparam logic [7:0] ASCII_STOP = 8'h3B;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'd0,
    CMD_FWD   = 3'd1,
    CMD_REV   = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_LEFT  = 3'd4,
    CMD_NITRO = 3'd5
  } cmd_e;

  typedef enum logic [1:0] {
    ST_STOP,
    ST_BRAKE,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic known;
    cmd_e cmd;
  } dec_t;

  function automatic dec_t decode(input logic [7:0] b);
    dec_t d;
    d.known = 1'b1;
    d.cmd   = CMD_IDLE;
    unique case (1'b1)
      (b == ASCII_F):    d.cmd = CMD_FWD;
      (b == ASCII_B):    d.cmd = CMD_REV;
      (b == ASCII_R):    d.cmd = CMD_RIGHT;
      (b == ASCII_L):    d.cmd = CMD_LEFT;
      (b == ASCII_N):    d.cmd = CMD_NITRO;
      (b == ASCII_STOP): d.cmd = CMD_IDLE;
      default:           d.known = 1'b0;
    endcase
    return d;
  endfunction

  // {l_fwd, l_rev, r_fwd, r_rev}
  function automatic logic [3:0] dir_of(input cmd_e c);
    logic [3:0] d;
    d = 4'b0000;
    unique case (c)
      CMD_FWD,
      CMD_NITRO: d = 4'b1010;
      CMD_REV:   d = 4'b0101;
      CMD_RIGHT: d = 4'b1001;
      CMD_LEFT:  d = 4'b0110;
      default:   d = 4'b0000;
    endcase
    return d;
  endfunction

  function automatic logic reverses(
    input logic [3:0] cur,
    input logic [3:0] nxt
  );
    return (cur[3] & nxt[2]) | (cur[2] & nxt[3]) |
           (cur[1] & nxt[0]) | (cur[0] & nxt[1]);
  endfunction

endpackage

// File: rtl/gesture_cmd_decoder_pwm_gen.sv
// Free-running 8-bit PWM; duty 255 is held constantly high.
// Output is registered.
module pwm_gen (
  input  logic       clk,
  input  logic       r_rstn,
  input  logic [7:0] duty,
  output logic       pwm_out
);

  logic [7:0] cnt;

  always_ff @(posedge clk or negedge r_rstn) begin
    if (!r_rstn) begin
      cnt     <= '0;
      pwm_out <= 1'b0;
    end else begin
      cnt     <= cnt + 8'd1;
      pwm_out <= (duty == 8'hFF) | (cnt < duty);
    end
  end

endmodule

// File: rtl/gesture_cmd_decoder.sv
// Gesture byte to motor command decoder with confirmation,
// brake-before-reverse and idle watchdog.
module gesture_cmd_decoder
  import gesture_cmd_decoder_pkg::*;
#(
  parameter int unsigned CONFIRM_CNT    = 3,
  parameter int unsigned TIMEOUT_CYCLES = 12_000_000,
  parameter int unsigned BRAKE_CYCLES   = 120_000,
  parameter logic [7:0]  DUTY_NORMAL    = 8'd160,
  parameter logic [7:0]  DUTY_NITRO     = 8'd255
) (
  input  logic       clk,
  input  logic       r_rstn,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [3:0] motor_dir,
  output logic       pwm_out,
  output logic [2:0] cmd_active,
  output logic       timeout,
  output logic       bad_byte
);

  localparam int CW = $clog2(CONFIRM_CNT + 1);
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BRAKE_CYCLES + 1);
  localparam logic [CW-1:0] CONF    = CW'(CONFIRM_CNT);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BK_LAST = BW'(BRAKE_CYCLES - 1);

  state_e        state;
  cmd_e          cmd_q;
  cmd_e          cand;
  logic [CW-1:0] count;
  logic [WW-1:0] wd;
  logic          armed;
  logic [BW-1:0] brk;
  logic [7:0]    duty;

  dec_t          dec;
  logic          known;
  logic          safe_stop;
  logic          motion;
  logic          same;
  logic [CW-1:0] count_nxt;
  logic          commit_go;
  logic          expire;
  cmd_e          cmd_nxt;
  logic [3:0]    dir_new;
  logic [7:0]    duty_new;

  assign dec       = decode(rx_data);
  assign known     = rx_valid & dec.known;
  assign safe_stop = known & (dec.cmd == CMD_IDLE);
  assign motion    = known & ~safe_stop;
  assign same      = (dec.cmd == cand);
  assign count_nxt = !same ? CW'(1) :
                     (count == CONF) ? count : count + 1'b1;
  // saturated repeats keep the command without re-triggering
  assign commit_go = motion & (count_nxt == CONF) &
                     ~(same & (count == CONF));
  assign expire    = armed & ~known & (wd == WD_LAST);
  assign cmd_nxt   = commit_go ? dec.cmd : cmd_q;
  assign dir_new   = dir_of(cmd_nxt);
  assign duty_new  = (cmd_nxt == CMD_NITRO) ? DUTY_NITRO : DUTY_NORMAL;
  assign cmd_active = cmd_q;

  always_ff @(posedge clk or negedge r_rstn) begin
    if (!r_rstn) begin
      state     <= ST_STOP;
      cmd_q     <= CMD_IDLE;
      cand      <= CMD_IDLE;
      count     <= '0;
      wd        <= '0;
      armed     <= 1'b0;
      brk       <= '0;
      duty      <= '0;
      motor_dir <= '0;
      timeout   <= 1'b0;
      bad_byte  <= 1'b0;
    end else begin
      bad_byte <= rx_valid & ~dec.known;
      if (known) begin
        wd      <= '0;
        armed   <= 1'b1;
        timeout <= 1'b0;
      end else if (expire) begin
        armed   <= 1'b0;
        timeout <= 1'b1;
      end else if (armed) begin
        wd <= wd + 1'b1;
      end
      if (motion) begin
        cand  <= dec.cmd;
        count <= count_nxt;
      end else if (safe_stop | expire) begin
        cand  <= CMD_IDLE;
        count <= '0;
      end
      if (safe_stop | expire) begin
        state     <= ST_STOP;
        cmd_q     <= CMD_IDLE;
        motor_dir <= '0;
        duty      <= '0;
      end else begin
        cmd_q <= cmd_nxt;
        unique case (state)
          ST_STOP: begin
            if (commit_go) begin
              state     <= ST_RUN;
              motor_dir <= dir_new;
              duty      <= duty_new;
            end
          end
          ST_RUN: begin
            if (commit_go) begin
              if (reverses(motor_dir, dir_new)) begin
                state     <= ST_BRAKE;
                motor_dir <= '0;
                duty      <= '0;
                brk       <= '0;
              end else begin
                motor_dir <= dir_new;
                duty      <= duty_new;
              end
            end
          end
          ST_BRAKE: begin
            if (brk == BK_LAST) begin
              state     <= ST_RUN;
              motor_dir <= dir_new;
              duty      <= duty_new;
            end else begin
              brk <= brk + 1'b1;
            end
          end
          default: state <= ST_STOP;
        endcase
      end
    end
  end

  pwm_gen u_pwm (
    .clk     (clk),
    .r_rstn  (r_rstn),
    .duty    (duty),
    .pwm_out (pwm_out)
  );

endmodule
